// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART: parity modes, TX/RX FSM states
// and the oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Mode 11 is reserved and behaves as no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: the head entry is presented combinationally while not empty.
// Writes when full are dropped unless a read frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_do_rd, w_do_wr;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_fifo_cfg.sv
// Configurable UART (5..8 data bits, parity, 1/2 stop bits, runtime divisor)
// with a valid/ready transmitter and an RX FIFO carrying per-character error flags.
module uart_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int RX_DEPTH    = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 RxD,
  output logic                 TxD,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 tx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic [DIV_W-1:0] r_tx_div, r_rx_div;
  logic             w_tx_tick, w_rx_tick, w_rx_start;

  assign w_tx_tick = (r_tx_div == '0);
  assign w_rx_tick = (r_rx_div == '0);

  // Independent tick generators; RX restarts its phase on every start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_div <= '0;
      r_rx_div <= '0;
    end else begin
      r_tx_div <= w_tx_tick ? baud_div : r_tx_div - DIV_W'(1);
      if (w_rx_start) r_rx_div <= baud_div;
      else            r_rx_div <= w_rx_tick ? baud_div : r_rx_div - DIV_W'(1);
    end
  end

  tx_state_t            r_tx_st, w_tx_nxt;
  logic                 r_tx_pend, r_txd, w_txd_nxt, w_tx_adv, w_tx_hs, w_tx_dbit;
  logic [TW-1:0]        r_tx_tcnt;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_tx_par, r_tx_paren, r_tx_stop2;

  assign tx_ready  = (r_tx_st == TX_IDLE) && !r_tx_pend;
  assign tx_busy   = !tx_ready;
  assign TxD       = r_txd;
  assign w_tx_hs   = tx_valid && tx_ready;
  assign w_tx_adv  = w_tx_tick && (r_tx_tcnt == T_END);
  assign w_tx_dbit = ((r_tx_st == TX_DATA) && w_tx_adv) ? r_tx_sh[1] : r_tx_sh[0];

  always_comb begin
    w_tx_nxt  = r_tx_st;
    w_txd_nxt = 1'b1;
    case (r_tx_st)
      TX_IDLE:   if (r_tx_pend && w_tx_tick) w_tx_nxt = TX_START;
      TX_START:  if (w_tx_adv) w_tx_nxt = TX_DATA;
      TX_DATA:   if (w_tx_adv && r_tx_bit == B_LAST)
                   w_tx_nxt = r_tx_paren ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (w_tx_adv) w_tx_nxt = TX_STOP1;
      TX_STOP1:  if (w_tx_adv) w_tx_nxt = r_tx_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (w_tx_adv) w_tx_nxt = TX_IDLE;
      default:   w_tx_nxt = TX_IDLE;
    endcase
    case (w_tx_nxt)
      TX_START:  w_txd_nxt = 1'b0;
      TX_DATA:   w_txd_nxt = w_tx_dbit;
      TX_PARITY: w_txd_nxt = r_tx_par;
      default:   w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_st   <= TX_IDLE;
      r_tx_pend <= 1'b0;
      r_tx_tcnt <= '0;
      r_tx_bit  <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_tx_st <= w_tx_nxt;
      r_txd   <= w_txd_nxt;
      if (w_tx_hs) r_tx_pend <= 1'b1;
      else if (w_tx_nxt == TX_START) r_tx_pend <= 1'b0;
      if (w_tx_nxt != r_tx_st) r_tx_tcnt <= '0;
      else if (w_tx_tick)      r_tx_tcnt <= r_tx_tcnt + TW'(1);
      if (r_tx_st == TX_START)                  r_tx_bit <= '0;
      else if (r_tx_st == TX_DATA && w_tx_adv)  r_tx_bit <= r_tx_bit + BW'(1);
    end
  end

  // Character and frame format are frozen at the handshake.
  always_ff @(posedge clk) begin
    if (w_tx_hs) begin
      r_tx_sh    <= tx_data;
      r_tx_par   <= (^tx_data) ^ (parity_mode == PAR_ODD);
      r_tx_paren <= par_enabled(parity_mode);
      r_tx_stop2 <= stop2;
    end else if (r_tx_st == TX_DATA && w_tx_adv) begin
      r_tx_sh <= r_tx_sh >> 1;
    end
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev, w_rxs, w_rx_mid, w_rx_adv, w_rx_wr, w_rx_perr;
  rx_state_t              r_rx_st, w_rx_nxt;
  logic [TW-1:0]          r_rx_tcnt;
  logic [BW-1:0]          r_rx_bit;
  logic [DATA_BITS-1:0]   r_rx_sh;
  logic                   r_rx_pbit, r_rx_paren, r_rx_odd;

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_rx_start = (r_rx_st == RX_IDLE) && r_rx_prev && !w_rxs;
  assign w_rx_mid   = w_rx_tick && (r_rx_tcnt == T_MID);
  assign w_rx_adv   = w_rx_tick && (r_rx_tcnt == T_END);
  assign w_rx_wr    = (r_rx_st == RX_STOP) && w_rx_mid;
  assign w_rx_perr  = r_rx_paren && (r_rx_pbit != ((^r_rx_sh) ^ r_rx_odd));

  // A frame starts only on a high-to-low edge, so a held break never re-arms.
  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:   if (w_rx_start) w_rx_nxt = RX_START;
      RX_START:  if (w_rx_mid && w_rxs) w_rx_nxt = RX_IDLE;
                 else if (w_rx_adv)     w_rx_nxt = RX_DATA;
      RX_DATA:   if (w_rx_adv && r_rx_bit == B_LAST)
                   w_rx_nxt = r_rx_paren ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_adv) w_rx_nxt = RX_STOP;
      RX_STOP:   if (w_rx_mid) w_rx_nxt = RX_IDLE;
      default:   w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= RX_IDLE;
      r_rx_tcnt <= '0;
      r_rx_bit  <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], RxD};
      r_rx_prev <= w_rxs;
      r_rx_st   <= w_rx_nxt;
      if (w_rx_nxt != r_rx_st) r_rx_tcnt <= '0;
      else if (w_rx_tick)      r_rx_tcnt <= r_rx_tcnt + TW'(1);
      if (r_rx_st == RX_START)                 r_rx_bit <= '0;
      else if (r_rx_st == RX_DATA && w_rx_adv) r_rx_bit <= r_rx_bit + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_start) begin
      r_rx_paren <= par_enabled(parity_mode);
      r_rx_odd   <= (parity_mode == PAR_ODD);
    end
    if (r_rx_st == RX_DATA && w_rx_mid)   r_rx_sh   <= {w_rxs, r_rx_sh[DATA_BITS-1:1]};
    if (r_rx_st == RX_PARITY && w_rx_mid) r_rx_pbit <= w_rxs;
  end

  logic [DATA_BITS+1:0] w_head;
  logic                 w_full, w_empty, r_ovr;

  uart_rx_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(RX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_wr    (w_rx_wr),
    .i_wdata ({w_rx_perr, ~w_rxs, r_rx_sh}),
    .i_rd    (rx_rd),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_ovr <= 1'b0;
    else if (w_rx_wr && w_full && !rx_rd)    r_ovr <= 1'b1;
    else if (rx_rd && !w_empty)              r_ovr <= 1'b0;
  end

  assign rx_empty   = w_empty;
  assign rx_overrun = r_ovr;
  assign {rx_perr, rx_ferr, rx_data} = w_empty ? '0 : w_head;

endmodule

// File: tb/tb_uart_fifo_cfg.sv
// Bench for uart_fifo_cfg at baud_div=3 (64 clk per bit): loopback vectors,
// raw RX frames for parity/framing/glitch/overrun, and reset mid-frame.
module tb_uart_fifo_cfg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2, RxD, TxD, tx_valid, tx_ready, rx_rd, rx_empty;
  logic [7:0]  tx_data, rx_data;
  logic        rx_perr, rx_ferr, rx_overrun, tx_busy;
  logic        lb, rxd_drv;

  always #5 clk = ~clk;
  assign RxD = lb ? TxD : rxd_drv;

  uart_fifo_cfg dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .RxD(RxD), .TxD(TxD), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_overrun(rx_overrun), .tx_busy(tx_busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [7:0] d; logic perr; logic ferr; } rx_exp_t;
  typedef struct { logic [7:0] d; logic [1:0] pm; logic s2; } vec_t;
  rx_exp_t sb[$];
  vec_t    vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic odd_ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return (n % 2) == 1;
  endfunction

  function automatic logic has_par(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  // Bit i of the result is the i-th bit on the wire; unused upper bits are idle 1.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic [1:0] pm,
                                           input logic flip);
    logic [15:0] f;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pm == 2'b01) f[9] = odd_ones(d) ^ flip;
    if (pm == 2'b10) f[9] = ~odd_ones(d) ^ flip;
    return f;
  endfunction

  task automatic send_raw(input logic [7:0] d, input logic [1:0] pm, input logic flip,
                          input logic stopv);
    logic [15:0] f;
    int nb;
    nb = has_par(pm) ? 11 : 10;
    f = mk_frame(d, pm, flip);
    f[nb-1] = stopv;
    for (int i = 0; i < nb; i++) begin
      rxd_drv = f[i];
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic rx_pop(input string nm);
    rx_exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard has no expected entry", nm);
      return;
    end
    e = sb.pop_front();
    chk(nm, 32'({rx_empty, rx_perr, rx_ferr, rx_data}), 32'({1'b0, e.perr, e.ferr, e.d}));
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic tx_vec(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                        input string nm);
    int nb, cnt, wt;
    logic [15:0] got, exp, mask;
    nb   = 10 + (has_par(pm) ? 1 : 0) + (s2 ? 1 : 0);
    exp  = mk_frame(d, pm, 1'b0);
    mask = 16'((32'd1 << nb) - 1);
    parity_mode = pm;
    stop2 = s2;
    tx_data = d;
    tx_valid = 1'b1;
    wt = 0;
    while (!tx_ready && wt < 2000) begin @(negedge clk); wt++; end
    @(negedge clk);
    tx_valid = 1'b0;
    sb.push_back('{d, 1'b0, 1'b0});
    chk({nm, " busy"}, 32'(tx_busy), 32'd1);
    wt = 0;
    while (TxD && wt < 200) begin @(negedge clk); wt++; end
    if (TxD) begin
      total++;
      bad++;
      $display("FAIL %s start: no start bit within 200 clk", nm);
      return;
    end
    cnt = 0;
    got = 16'hFFFF;
    while (!tx_ready && cnt < 1000) begin
      if (cnt % 64 == 32 && cnt / 64 < 16) got[cnt/64] = TxD;
      @(negedge clk);
      cnt++;
    end
    chk({nm, " frame"}, 32'(got & mask), 32'(exp & mask));
    chk({nm, " ready clk"}, 32'(cnt), 32'(64 * nb));
    rx_pop({nm, " rx"});
  endtask

  initial begin
    int wt;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; lb = 1'b1; rxd_drv = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        32'({TxD, tx_ready, tx_busy, rx_empty, rx_perr, rx_ferr, rx_overrun, rx_data}),
        32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{8'hA5, 2'b00, 1'b0};
    vecs[1] = '{8'h55, 2'b01, 1'b0};
    vecs[2] = '{8'h55, 2'b10, 1'b0};
    vecs[3] = '{8'h3C, 2'b01, 1'b1};
    vecs[4] = '{8'hFF, 2'b11, 1'b0};
    vecs[5] = '{8'h01, 2'b10, 1'b1};
    for (int i = 0; i < 6; i++) tx_vec(vecs[i].d, vecs[i].pm, vecs[i].s2, $sformatf("vec%0d", i));

    // Parity bit flipped on an even-parity frame
    lb = 1'b0; stop2 = 1'b0; parity_mode = 2'b01;
    sb.push_back('{8'h55, 1'b1, 1'b0});
    send_raw(8'h55, 2'b01, 1'b1, 1'b1);
    rx_pop("parity flip");

    // Stop bit low, line held low (break), then released
    parity_mode = 2'b00;
    sb.push_back('{8'h3A, 1'b0, 1'b1});
    send_raw(8'h3A, 2'b00, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    rx_pop("framing err");
    repeat (192) @(negedge clk);
    chk("break no rearm", 32'(rx_empty), 32'd1);
    rxd_drv = 1'b1;
    repeat (128) @(negedge clk);
    sb.push_back('{8'h81, 1'b0, 1'b0});
    send_raw(8'h81, 2'b00, 1'b0, 1'b1);
    rx_pop("rearm after break");

    // Three-tick low glitch
    rxd_drv = 1'b0;
    repeat (12) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch no write", 32'(rx_empty), 32'd1);
    sb.push_back('{8'hC6, 1'b0, 1'b0});
    send_raw(8'hC6, 2'b00, 1'b0, 1'b1);
    rx_pop("after glitch");

    // Overrun: 17 characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back('{8'(i * 13 + 7), 1'b0, 1'b0});
      send_raw(8'(i * 13 + 7), 2'b00, 1'b0, 1'b1);
    end
    chk("overrun flags", 32'({rx_empty, rx_overrun}), 32'({1'b0, 1'b1}));
    rx_pop("overrun head");
    chk("overrun cleared", 32'(rx_overrun), 32'd0);
    for (int i = 1; i < 16; i++) rx_pop($sformatf("drain%0d", i));
    chk("17th absent", 32'(rx_empty), 32'd1);

    // Reset during TX and RX data phase (loopback)
    lb = 1'b1; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wt = 0;
    while (TxD && wt < 200) begin @(negedge clk); wt++; end
    repeat (200) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset mid-frame",
        32'({TxD, tx_ready, tx_busy, rx_empty, rx_overrun}),
        32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0}));
    @(negedge clk) rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("no stale rx", 32'(rx_empty), 32'd1);
    tx_vec(8'hC3, 2'b00, 1'b0, "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
